inst_queue: RTL
===============

# inst_queue

Parametrised, multi-entry replacement for the single-slot IF→ID stage register in the RV32I pipeline. It buffers fetched instruction payloads in a circular FIFO with valid/ready handshakes on both sides and a single-cycle flush for branch redirect. It also stamps each accepted entry with a 64-bit retire order, and rewinds the order counter when entries are squashed.

## Interface
- DEPTH, 4: number of entries; power of two, ≥ 2.
- WIDTH, 96: payload width in bits (pc, pc_next, inst).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  queue accepts this cycle.
- in_data  in  WIDTH  payload.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes head.
- out_data  out  WIDTH  head payload.
- out_order  out  64  order stamp of head.
- flush  in  1  squash all entries (branch/jump redirect).
- count  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Push = in_valid && in_ready. Pop = out_valid && out_ready.
- Storage: head pointer, tail pointer and count.
  - Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH-1 → 0.
  - count is registered.
- in_ready = (count != DEPTH).
  - Derived from registered state only; there is no combinational path from out_ready.
  - When the queue is full, a same-cycle pop does not enable a push.
- out_valid = (count != 0). out_data and out_order come from the head entry.
- Order counter: 64 bits, reset 0. Each push writes the current value into the entry's order field, then increments by 1, wrapping modulo 2^64.
- Flush, synchronous:
  - Next cycle, count = 0, head = tail, and out_valid = 0.
  - If count != 0, the order counter is set to the head entry's stamp, so squashed instructions never consume order numbers.
  - If count == 0, the order counter is unchanged.
  - Flush overrides a same-cycle push and pop: neither takes effect, and the order counter does not increment.
- Simultaneous push and pop when 0 < count < DEPTH: count is unchanged and both pointers advance.
- Push while empty: the entry becomes visible on out_* the next cycle.
- Pop while count == 1 and no push: the queue is empty the next cycle.

## Timing
- Reset values (asynchronous on rst_n low):
  - count = 0, head = tail = 0, order counter = 0.
  - out_valid = 0, in_ready = 1.
  - out_data = 0, out_order = 0. Storage is cleared at reset.
- Latency without bypass: 1 cycle from push to out_valid.
- Throughput: 1 push and 1 pop per cycle sustained whenever 0 < count < DEPTH.
- Reset asserted mid-operation discards all entries and the order state immediately, without waiting for a clock edge.
- Handshake rules:
  - Upstream holds in_data stable while in_valid && !in_ready.
  - The queue holds out_data and out_order stable while out_valid && !out_ready, except across a flush.

## Configuration
- INST_QUEUE_BYPASS_EN defined:
  - When count == 0 and in_valid, the queue asserts out_valid the same cycle, with out_data = in_data and out_order = the current order counter.
  - If out_ready is also high, the payload passes through without being written. The order counter still increments, and the pointers and count are unchanged.
  - If out_ready is low, the payload is written normally.
  - flush suppresses the bypass: out_valid = 0 in a flush cycle while empty.
- INST_QUEUE_BYPASS_EN undefined: 1-cycle minimum latency as above; out_* depend only on registered state.

## Structure
- rv32i_types gains:
  - order_t: logic [63:0].
  - inst_q_entry_t: a packed struct of payload plus order_t.
- One sub-module, inst_queue_mem:
  - DEPTH × $bits(inst_q_entry_t) register array, async read at head, sync write at tail.
  - Reset clears the array.
- Control logic (pointers, count, order counter, flush) lives in inst_queue.

## Test plan
- Reset, then push 0xA, 0xB, 0xC with out_ready=0 → count=3; the next pop yields data 0xA with out_order=0.
- DEPTH=4: push 4 entries, in_valid held high with out_ready=1 on the cycle count=4 → in_ready=0 that cycle, no 5th write; count goes 4→3.
- Push 6 entries, pop 3, push 3 → pointers wrap. Pop order is data 4,5,6,7,8,9 with out_order 3..8 (entry 4 was the 4th push, so its stamp is 3).
- Push 5 entries (orders 0–4), pop 2, flush → count=0; next push is stamped out_order=2. Flush with a same-cycle push → nothing is written.
- Continuous push/pop at count=2 for 20 cycles → count stays 2, no drops, out_order strictly +1 per pop.
- With INST_QUEUE_BYPASS_EN and an empty queue: in_valid=1, out_ready=1, data 0x55 → out_valid=1 the same cycle, out_data=0x55, count stays 0. Without the macro → out_valid rises one cycle later.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// Shared RV32I pipeline types used by the instruction queue.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package rv32i_types;

    // Default fetch payload: pc, pc_next and inst, 32 bits each.
    localparam int INST_Q_PAYLOAD_W = 96;

    // Retire-order stamp carried alongside every queued instruction.
    typedef logic [63:0] order_t;

    typedef struct packed {
        logic [INST_Q_PAYLOAD_W-1:0] payload;
        order_t                      order;
    } inst_q_entry_t;

endpackage

// File: rtl/inst_queue_mem.sv
// Entry storage for inst_queue: DEPTH x ENTRY_W registers.
// Latency: asynchronous read at rd_addr, write lands on the next rising clk edge.
// Backpressure: none; the controller decides when to write.
// Ports: clk/rst_n, wr_en/wr_addr/wr_data (write port), rd_addr/rd_data (read port).
module inst_queue_mem #(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = 160
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [ENTRY_W-1:0]       wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [ENTRY_W-1:0]       rd_data
);

    logic [DEPTH-1:0][ENTRY_W-1:0] mem_q;
    logic [DEPTH-1:0][ENTRY_W-1:0] mem_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Clearing on reset makes out_data/out_order read as zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/inst_queue.sv
// Multi-entry IF->ID instruction FIFO with retire-order stamping and single-cycle flush.
// Latency: 1 cycle push to out_valid; 0 cycles when empty with INST_QUEUE_BYPASS_EN defined.
// Backpressure: in_ready = not full (registered state only); out_valid held until out_ready.
// Ports: clk/rst_n; in_valid/in_ready/in_data upstream; out_valid/out_ready/out_data/out_order
// downstream; flush squashes all entries; count is the registered occupancy.
// Option: define INST_QUEUE_BYPASS_EN for empty-queue same-cycle pass-through.
module inst_queue
    import rv32i_types::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [63:0]                out_order,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // Same layout as inst_q_entry_t, but following the WIDTH parameter.
    typedef struct packed {
        logic [WIDTH-1:0] payload;
        order_t           order;
    } entry_t;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    order_t           order_q, order_d;

    entry_t wr_entry;
    entry_t rd_entry;
    logic   bypass;
    logic   push;
    logic   pop;
    logic   wr_en;
    logic   store_pop;
    logic   not_empty;

    always_comb begin
        not_empty = (count_q != '0);
        in_ready  = (count_q != CNT_W'(DEPTH));

`ifdef INST_QUEUE_BYPASS_EN
        bypass = !not_empty && in_valid && !flush;
`else
        bypass = 1'b0;
`endif

        out_valid = not_empty || bypass;
        out_data  = bypass ? in_data : rd_entry.payload;
        out_order = bypass ? order_q : rd_entry.order;

        // Flush wins over both handshakes in the same cycle.
        push      = in_valid && in_ready && !flush;
        pop       = out_valid && out_ready && !flush;
        // A bypassed payload consumed in the same cycle never touches storage.
        wr_en     = push && !(bypass && out_ready);
        store_pop = pop && not_empty;

        wr_entry.payload = in_data;
        wr_entry.order   = order_q;

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        order_d = order_q;

        if (flush) begin
            count_d = '0;
            head_d  = tail_q;
            // Rewind so squashed entries give their order numbers back.
            if (not_empty) begin
                order_d = rd_entry.order;
            end
        end else begin
            if (push) begin
                order_d = order_q + 64'd1;
            end
            if (wr_en) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (store_pop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(wr_en) - CNT_W'(store_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            order_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            order_q <= order_d;
        end
    end

    assign count = count_q;

    inst_queue_mem #(
        .DEPTH   (DEPTH),
        .ENTRY_W ($bits(entry_t))
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (tail_q),
        .wr_data (wr_entry),
        .rd_addr (head_q),
        .rd_data (rd_entry)
    );

endmodule
